stpu_fetch: RTL and testbench
=============================

Name: stpu_fetch

Overview:
- Instruction-fetch front end of the stpu core.
- Drives the instruction ROM address and chip enable, and captures the combinationally read instruction word.
- Buffers fetched {pc, inst} pairs in a small prefetch FIFO and hands them to the decode stage over a valid/ready handshake.
- Accepts a redirect (branch/jump) from downstream, which flushes the buffer and restarts fetch at the new PC.

Parameters:
- DEPTH, 2, prefetch FIFO entries; power of two, 2..8.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr_o  out  32 (`InstAddrBus)  byte address of the current fetch; the SoC connects the word-index bits [ADDR_W+1:2] to the ROM.
- rom_ce  out  1  ROM chip enable; high only in a fetch cycle.
- rom_data_i  in  32 (`InstBus)  ROM read data, valid in the same cycle as rom_addr_o.
- redirect_i  in  1  flush the buffer and restart fetch.
- redirect_pc_i  in  32  new fetch address.
- id_valid_o  out  1  head entry valid.
- id_ready_i  in  1  decode accepts the head entry this cycle.
- id_pc_o  out  32  PC of the head entry.
- id_inst_o  out  32  instruction of the head entry.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc<=RESET_PC, started<=0, FIFO emptied (count=0, pointers 0).
  - Outputs: rom_ce=0, id_valid_o=0, id_pc_o=0, id_inst_o=`ZeroWord.
  - Reset asserted mid-operation discards all buffered entries and any in-progress fetch. No entry survives.
- started is a register set to 1 on the first edge with rst=0.
- rom_ce = started & ~redirect_i & (count<DEPTH).
  - count is the registered occupancy. A same-cycle pop does not free a slot, so there is no combinational path from id_ready_i to rom_ce.
- rom_addr_o = pc at all times. Its value is don't-care when rom_ce=0.
- Fetch cycle (rom_ce=1):
  - Push {pc, rom_data_i} at the tail.
  - pc<=pc+4, wrapping 32'hFFFF_FFFC -> 0. No overflow flag.
- Output side:
  - id_valid_o = (count!=0).
  - id_pc_o / id_inst_o show the head entry; they hold stable while valid and not accepted.
  - When the FIFO is empty, id_pc_o / id_inst_o hold their last values and are don't-care.
  - Pop occurs on id_valid_o & id_ready_i.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count=DEPTH): rom_ce=0, pc holds, and nothing is lost.
- Empty with id_ready_i=1: no pop, and count never underflows.
- Redirect (redirect_i=1) has highest priority:
  - FIFO is flushed, count<=0, and any same-cycle pop is ignored.
  - No push; pc<={redirect_pc_i[31:2],2'b00} (misaligned low bits are forced to 0).
  - id_valid_o=0 in the following cycle.
  - The first post-redirect instruction is presented 2 cycles after the redirect edge: fetch in cycle +1, valid in cycle +2.
- Latency:
  - First edge with rst=0 is edge E0, giving started=1.
  - Cycle after E0: rom_ce=1, fetch RESET_PC.
  - After edge E1: id_valid_o=1 with the RESET_PC instruction.
- Steady-state throughput is 1 instruction/cycle whenever DEPTH>=2 and id_ready_i stays high.
- rom_ce is never high in the same cycle as rst or redirect_i.

Decomposition:
- Defines.vh supplies the existing macros: `InstAddrBus, `InstBus, `ZeroWord, `RstEnable, `ChipEnable, `ChipDisable.
- Add to Defines.vh: `PcStep (32'd4) and `FetchDepth (default DEPTH).
- One sub-module: stpu_fetch_fifo.
  - Parameterised by DEPTH and width 64.
  - Ports: push, pop, flush, din, dout, count/full/empty.
  - Synchronous reset; flush has priority over push/pop.
- stpu_fetch holds the PC register, the started flag and the rom_ce/redirect logic.
- stpu instantiates stpu_fetch in place of its pc register and IF/ID register.

Test Plan:
- Free run: ROM word k = 32'h1000_0000+k; release rst; id_ready_i=1 -> id_valid_o rises 2 edges after release; stream pc 0,4,8,... with inst 0x10000000,0x10000001,... one per cycle, no gaps or duplicates.
- Backpressure: id_ready_i=0 for 6 cycles -> exactly DEPTH=2 entries buffered (pc 0,4); rom_ce=0 once full; head held stable; on ready=1, sequence resumes at pc 8 with no loss.
- Redirect while full: buffer full, redirect_i=1 with redirect_pc_i=32'h0000_0013 -> next cycle id_valid_o=0; fetch at 0x10, then 0x14; the old entries are never presented.
- Redirect with simultaneous pop: id_valid_o=1, id_ready_i=1, redirect_i=1 -> count=0 after the edge; the next valid entry has id_pc_o=redirect target.
- Wrap: redirect to 32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004 delivered in order.
- Reset mid-operation: assert rst for 1 cycle with 2 entries buffered -> next cycle id_valid_o=0 and rom_ce=0; after release, fetch restarts at RESET_PC with 2-cycle latency.

Source files
------------

// File: rtl/stpu_fetch_pkg.sv
// stpu_fetch_pkg: shared constants and the prefetch entry layout for the fetch front end
package stpu_fetch_pkg;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int FETCH_DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/stpu_fetch_fifo.sv
// stpu_fetch_fifo: small circular prefetch buffer with flush taking priority over push/pop
module stpu_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push_e, pop_e;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_e = push & ~full & ~flush;
  assign pop_e = pop & ~empty & ~flush;
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= push_e ? wr + 1'b1 : wr;
      rd <= pop_e ? rd + 1'b1 : rd;
      count <= count + CW'(push_e) - CW'(pop_e);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_e) begin
      mem[wr] <= din;
    end
  end
endmodule

// File: rtl/stpu_fetch.sv
// stpu_fetch: pc register, rom fetch control and redirect handling feeding a prefetch buffer to decode
module stpu_fetch
  import stpu_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] pc;
  logic started, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t din, dout;
  assign rom_addr_o = pc;
  assign rom_ce = started & ~rst & ~redirect_i & ~full;
  assign din = '{pc: pc, inst: rom_data_i};
  assign id_valid_o = ~empty;
  assign id_pc_o = dout.pc;
  assign id_inst_o = dout.inst;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      pc <= redirect_i ? {redirect_pc_i[31:2], 2'b00} : rom_ce ? pc + PC_STEP : pc;
    end
  end
  stpu_fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rom_ce),
    .pop(id_ready_i & (count != '0)),
    .flush(redirect_i),
    .din(din),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_stpu_fetch.sv
// tb_stpu_fetch: directed vector table plus a backpressure stream check for the fetch front end
module tb_stpu_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect_i = 1'b0;
  logic id_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] rom_addr_o, rom_data_i, id_pc_o, id_inst_o;
  logic rom_ce, id_valid_o;
  int n_vec = 0;
  int n_miss = 0;
  typedef struct {
    logic rst;
    logic rdy;
    logic red;
    logic [31:0] rpc;
    logic ev;
    logic ece;
    logic chk_d;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  assign rom_data_i = 32'h1000_0000 + {2'b00, rom_addr_o[31:2]};
  stpu_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr_o(rom_addr_o),
    .rom_ce(rom_ce),
    .rom_data_i(rom_data_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o)
  );
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask
  task automatic v(input logic r, input logic rdy, input logic red, input logic [31:0] rpc,
                   input logic ev, input logic ece, input logic cd, input logic [31:0] epc, input logic [31:0] ei);
    tbl.push_back('{r, rdy, red, rpc, ev, ece, cd, epc, ei});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int exp_pc, acc, rdy_cycles;
    v(1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    v(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    v(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    v(0, 1, 0, 0, 1, 1, 1, 32'h0, 32'h1000_0000);
    v(0, 1, 0, 0, 1, 1, 1, 32'h4, 32'h1000_0001);
    v(0, 0, 0, 0, 1, 1, 1, 32'h8, 32'h1000_0002);
    v(0, 0, 0, 0, 1, 0, 1, 32'h8, 32'h1000_0002);
    v(0, 0, 0, 0, 1, 0, 1, 32'h8, 32'h1000_0002);
    v(0, 0, 0, 0, 1, 0, 1, 32'h8, 32'h1000_0002);
    v(0, 1, 0, 0, 1, 0, 1, 32'h8, 32'h1000_0002);
    v(0, 1, 0, 0, 1, 1, 1, 32'hC, 32'h1000_0003);
    v(0, 1, 0, 0, 1, 1, 1, 32'h10, 32'h1000_0004);
    v(0, 0, 0, 0, 1, 1, 1, 32'h14, 32'h1000_0005);
    v(0, 0, 1, 32'h13, 1, 0, 1, 32'h14, 32'h1000_0005);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    v(0, 0, 0, 0, 1, 1, 1, 32'h10, 32'h1000_0004);
    v(0, 1, 0, 0, 1, 0, 1, 32'h10, 32'h1000_0004);
    v(0, 1, 0, 0, 1, 1, 1, 32'h14, 32'h1000_0005);
    v(0, 1, 1, 32'h100, 1, 0, 1, 32'h18, 32'h1000_0006);
    v(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    v(0, 1, 0, 0, 1, 1, 1, 32'h100, 32'h1000_0040);
    v(0, 1, 1, 32'hFFFF_FFF8, 1, 0, 1, 32'h104, 32'h1000_0041);
    v(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    v(0, 1, 0, 0, 1, 1, 1, 32'hFFFF_FFF8, 32'h4FFF_FFFE);
    v(0, 1, 0, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
    v(0, 1, 0, 0, 1, 1, 1, 32'h0, 32'h1000_0000);
    v(0, 0, 0, 0, 1, 1, 1, 32'h4, 32'h1000_0001);
    v(0, 0, 0, 0, 1, 0, 1, 32'h4, 32'h1000_0001);
    v(1, 0, 0, 0, 1, 0, 1, 32'h4, 32'h1000_0001);
    v(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    v(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    v(0, 1, 0, 0, 1, 1, 1, 32'h0, 32'h1000_0000);
    v(0, 1, 0, 0, 1, 1, 1, 32'h4, 32'h1000_0001);
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      id_ready_i = tbl[i].rdy;
      redirect_i = tbl[i].red;
      redirect_pc_i = tbl[i].rpc;
      #1;
      n_vec++;
      chk("id_valid", i, {31'b0, id_valid_o}, {31'b0, tbl[i].ev});
      chk("rom_ce", i, {31'b0, rom_ce}, {31'b0, tbl[i].ece});
      if (tbl[i].chk_d) begin
        chk("id_pc", i, id_pc_o, tbl[i].epc);
        chk("id_inst", i, id_inst_o, tbl[i].einst);
      end
      if (rom_ce) chk("rom_addr_aligned", i, {30'b0, rom_addr_o[1:0]}, 32'h0);
    end
    exp_pc = 8;
    acc = 0;
    rdy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst = 1'b0;
      redirect_i = 1'b0;
      id_ready_i = (i % 3) != 0;
      #1;
      if (id_ready_i) rdy_cycles++;
      if (id_valid_o && id_ready_i) begin
        n_vec++;
        chk("stream_pc", 100 + i, id_pc_o, 32'(exp_pc));
        chk("stream_inst", 100 + i, id_inst_o, 32'h1000_0000 + 32'(exp_pc / 4));
        exp_pc += 4;
        acc++;
      end
    end
    n_vec++;
    chk("stream_accepted", 200, 32'(acc), 32'(rdy_cycles));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
